// File: rtl/clk_div_pkg.sv
// Shared constants for the clock-enable scheduler: register map, CTRL bit
// positions and the channel state encoding.
package clk_div_pkg;

  localparam logic [31:0] LIMIT_OFS    = 32'h0000_0000;
  localparam logic [31:0] CTRL_OFS     = 32'h0000_0004;
  localparam logic [31:0] PRESCALE_OFS = 32'h0000_0040;
  localparam int          CH_STRIDE    = 8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_PENDING = 2;
  localparam int CTRL_DONE    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chan_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active LIMIT pair, wrap counter and the
// registered tick strobe / sclk toggle outputs.
//
// state | meaning
// IDLE  | EN=0, count held at 0, active LIMIT follows shadow every cycle
// RUN   | count advances on pre_tick, wraps when count equals active LIMIT
// DONE  | one-shot period finished, sclk frozen until EN is written again
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pre_tick,
  input  logic             i_limit_we,
  input  logic [CNT_W-1:0] i_limit_wdata,
  input  logic             i_ctrl_we,
  input  logic             i_ctrl_en,
  input  logic             i_ctrl_oneshot,
  input  logic             i_ctrl_done_clr,
  output logic             o_run,
  output logic [CNT_W-1:0] o_active,
  output logic [3:0]       o_ctrl,
  output logic             o_tick,
  output logic             o_sclk
);

  chan_state_e      r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_shadow;
  logic             r_oneshot;
  logic             r_done;
  logic             r_tick;
  logic             r_sclk;

  logic             w_disable;
  logic             w_enable;
  logic             w_wrap;
  logic [3:0]       w_ctrl;

  assign w_disable = i_ctrl_we && !i_ctrl_en;
  assign w_enable  = i_ctrl_we && i_ctrl_en;
  // A disable landing on the wrap edge suppresses the wrap entirely.
  assign w_wrap    = (r_state == RUN) && i_pre_tick && (r_count == r_active) && !w_disable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_active  <= '0;
      r_shadow  <= '0;
      r_oneshot <= 1'b0;
      r_done    <= 1'b0;
      r_tick    <= 1'b0;
      r_sclk    <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_wrap) r_sclk <= ~r_sclk;
      if (i_limit_we) r_shadow <= i_limit_wdata;
      if (i_ctrl_we) r_oneshot <= i_ctrl_oneshot;
      if (w_wrap && r_oneshot) r_done <= 1'b1;
      else if (i_ctrl_we && i_ctrl_done_clr) r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          r_count  <= '0;
          r_active <= r_shadow;
          if (w_enable) r_state <= RUN;
        end
        RUN: begin
          if (w_disable) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_active <= r_shadow;
          end else if (w_wrap) begin
            r_count  <= '0;
            r_active <= r_shadow;
            if (r_oneshot) r_state <= DONE;
          end else if (i_pre_tick) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        DONE: begin
          if (w_enable) r_state <= RUN;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_ctrl               = '0;
    w_ctrl[CTRL_EN]      = (r_state == RUN);
    w_ctrl[CTRL_ONESHOT] = r_oneshot;
    w_ctrl[CTRL_PENDING] = (r_shadow != r_active);
    w_ctrl[CTRL_DONE]    = r_done;
  end

  assign o_run    = (r_state == RUN);
  assign o_active = r_active;
  assign o_ctrl   = w_ctrl;
  assign o_tick   = r_tick;
  assign o_sclk   = r_sclk;

endmodule

// File: rtl/clk_div_sched.sv
// Multi-channel clock-enable scheduler: shared prescaler, MMIO decode and
// registered read mux around NUM_CH divider channels.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 24,
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic              bus_wr,
  input  logic              bus_rd,
  output logic [31:0]       bus_rdata,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sclk
);

  logic [31:0]       w_ofs;
  logic              w_pre_hit;
  logic [NUM_CH-1:0] w_lim_hit;
  logic [NUM_CH-1:0] w_ctrl_hit;
  logic [NUM_CH-1:0] w_run;
  logic [CNT_W-1:0]  w_active [NUM_CH];
  logic [3:0]        w_ctrl   [NUM_CH];
  logic              w_any_run;
  logic              w_pre_tick;
  logic [31:0]       w_rd_mux;
  logic              w_unused;

  logic [CNT_W-1:0]  r_pre_cnt;
  logic [CNT_W-1:0]  r_prescale;
  logic [31:0]       r_rdata;

  assign w_ofs     = bus_addr - BASE_ADDR;
  assign w_pre_hit = (w_ofs == PRESCALE_OFS);
  assign w_unused  = &{1'b0, bus_wdata};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_lim_hit[g]  = (w_ofs == LIMIT_OFS + 32'(g * CH_STRIDE));
    assign w_ctrl_hit[g] = (w_ofs == CTRL_OFS + 32'(g * CH_STRIDE));

    clk_div_chan #(.CNT_W(CNT_W)) u_chan (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_pre_tick      (w_pre_tick),
      .i_limit_we      (bus_wr && w_lim_hit[g]),
      .i_limit_wdata   (bus_wdata[CNT_W-1:0]),
      .i_ctrl_we       (bus_wr && w_ctrl_hit[g]),
      .i_ctrl_en       (bus_wdata[CTRL_EN]),
      .i_ctrl_oneshot  (bus_wdata[CTRL_ONESHOT]),
      .i_ctrl_done_clr (bus_wdata[CTRL_DONE]),
      .o_run           (w_run[g]),
      .o_active        (w_active[g]),
      .o_ctrl          (w_ctrl[g]),
      .o_tick          (tick[g]),
      .o_sclk          (sclk[g])
    );
  end

  // >= rather than == so a PRESCALE shrunk below pre_cnt wraps on the next cycle.
  assign w_any_run  = |w_run;
  assign w_pre_tick = w_any_run && (r_pre_cnt >= r_prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt  <= '0;
      r_prescale <= '0;
    end else begin
      if (!w_any_run || w_pre_tick) r_pre_cnt <= '0;
      else r_pre_cnt <= r_pre_cnt + CNT_W'(1);
      if (bus_wr && w_pre_hit) r_prescale <= bus_wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (w_pre_hit) w_rd_mux = 32'(r_prescale);
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_lim_hit[c])  w_rd_mux = 32'(w_active[c]);
      if (w_ctrl_hit[c]) w_rd_mux = 32'(w_ctrl[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= bus_rd ? w_rd_mux : '0;
  end

  assign bus_rdata = r_rdata;

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed timing cases with literal
// expectations plus randomized MMIO traffic against a cycle-level model.
module tb_clk_div_sched;

  localparam int          NCH  = 4;
  localparam logic [31:0] BASE = 32'h1100_0100;

  logic            clk;
  logic            rst_n;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic            bus_wr;
  logic            bus_rd;
  logic [31:0]     bus_rdata;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  sclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tick_q [NCH][$];

  // model state: m_left counts pre_ticks remaining before the next wrap
  logic [23:0] m_shadow [NCH];
  logic [23:0] m_active [NCH];
  logic [23:0] m_left   [NCH];
  bit          m_en     [NCH];
  bit          m_halt   [NCH];
  bit          m_done   [NCH];
  bit          m_os     [NCH];
  bit          m_sclk   [NCH];
  bit          m_tick   [NCH];
  logic [23:0] m_pre_cnt;
  logic [23:0] m_prescale;
  logic [31:0] m_rdata;

  clk_div_sched #(.NUM_CH(NCH), .CNT_W(24), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_rdata (bus_rdata),
    .tick      (tick),
    .sclk      (sclk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_shadow[c] = '0; m_active[c] = '0; m_left[c] = '0;
      m_en[c] = 0; m_halt[c] = 0; m_done[c] = 0; m_os[c] = 0;
      m_sclk[c] = 0; m_tick[c] = 0;
    end
    m_pre_cnt = '0; m_prescale = '0; m_rdata = '0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o == 32'h40) return {8'h0, m_prescale};
    for (int c = 0; c < NCH; c++) begin
      if (o == 32'(8 * c)) return {8'h0, m_active[c]};
      if (o == 32'(8 * c + 4))
        return {28'h0, m_done[c], m_shadow[c] != m_active[c], m_os[c], m_en[c]};
    end
    return 32'h0;
  endfunction

  function automatic void m_step();
    bit any_run, pre_tick, cw, lw, dis, ena, wrap;
    logic [31:0] o;
    logic [23:0] sh_old;
    any_run = 0;
    for (int c = 0; c < NCH; c++) any_run |= m_en[c];
    pre_tick = any_run && (m_pre_cnt >= m_prescale);
    m_rdata  = bus_rd ? m_read(bus_addr) : 32'h0;
    o = bus_addr - BASE;
    for (int c = 0; c < NCH; c++) begin
      cw  = bus_wr && (o == 32'(8 * c + 4));
      lw  = bus_wr && (o == 32'(8 * c));
      dis = cw && !bus_wdata[0];
      ena = cw && bus_wdata[0];
      wrap = m_en[c] && pre_tick && (m_left[c] == 0) && !dis;
      sh_old = m_shadow[c];
      m_tick[c] = wrap;
      if (wrap) m_sclk[c] = !m_sclk[c];
      if (wrap && m_os[c]) m_done[c] = 1;
      else if (cw && bus_wdata[3]) m_done[c] = 0;
      if (m_en[c]) begin
        if (dis) begin
          m_en[c] = 0; m_active[c] = sh_old;
        end else if (wrap) begin
          m_active[c] = sh_old; m_left[c] = sh_old;
          if (m_os[c]) begin m_en[c] = 0; m_halt[c] = 1; end
        end else if (pre_tick) begin
          m_left[c] = m_left[c] - 24'd1;
        end
      end else if (m_halt[c]) begin
        if (ena) begin m_en[c] = 1; m_halt[c] = 0; m_left[c] = m_active[c]; end
      end else begin
        m_active[c] = sh_old;
        if (ena) begin m_en[c] = 1; m_left[c] = sh_old; end
      end
      if (cw) m_os[c] = bus_wdata[1];
      if (lw) m_shadow[c] = bus_wdata[23:0];
    end
    if (!any_run || pre_tick) m_pre_cnt = '0;
    else m_pre_cnt = m_pre_cnt + 24'd1;
    if (bus_wr && o == 32'h40) m_prescale = bus_wdata[23:0];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  always @(negedge rst_n) m_reset();

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (tick[c] !== m_tick[c]) begin
          errors++;
          $display("FAIL model_tick ch%0d cyc %0d: actual=%b expected=%b", c, cyc, tick[c], m_tick[c]);
        end
        checks++;
        if (sclk[c] !== m_sclk[c]) begin
          errors++;
          $display("FAIL model_sclk ch%0d cyc %0d: actual=%b expected=%b", c, cyc, sclk[c], m_sclk[c]);
        end
        if (tick[c] === 1'b1) tick_q[c].push_back(cyc);
      end
      checks++;
      if (bus_rdata !== m_rdata) begin
        errors++;
        $display("FAIL model_rdata cyc %0d: actual=%h expected=%h", cyc, bus_rdata, m_rdata);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(posedge clk); #2;
    bus_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus_addr = a; bus_rd = 1'b1;
    @(posedge clk); #2;
    bus_rd = 1'b0;
    v = bus_rdata;
  endtask

  task automatic wait_ticks(input int c, input int n, input int budget, input string name);
    int k;
    k = 0;
    while (tick_q[c].size() < n && k < budget) begin @(posedge clk); #2; k++; end
    checks++;
    if (tick_q[c].size() < n) begin
      errors++;
      $display("FAIL %s timeout: actual=%0d ticks expected=%0d", name, tick_q[c].size(), n);
    end
  endtask

  task automatic clear_q();
    for (int c = 0; c < NCH; c++) tick_q[c].delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int n, tot;
    logic [31:0] a, d;
    int r, k;

    rst_n = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wr = 1'b0; bus_rd = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tick", tick, 0);
    chk("reset_sclk", sclk, 0);
    chk("reset_rdata", bus_rdata, 0);
    rst_n = 1'b1;
    idle(2);

    // ch0 LIMIT=3 PRESCALE=1: period 8 cycles from the EN edge
    wr(BASE + 32'h40, 1);
    wr(BASE + 32'h00, 3);
    clear_q();
    wr(BASE + 32'h04, 1);
    n = cyc;
    wait_ticks(0, 3, 100, "t1_ticks");
    chk("t1_tick0", tick_q[0][0] - n, 8);
    chk("t1_tick1", tick_q[0][1] - n, 16);
    chk("t1_tick2", tick_q[0][2] - n, 24);
    wr(BASE + 32'h04, 0);

    // ch1 one-shot LIMIT=2, PRESCALE=0
    wr(BASE + 32'h40, 0);
    wr(BASE + 32'h08, 2);
    clear_q();
    wr(BASE + 32'h0C, 3);
    n = cyc;
    idle(12);
    chk("t2_tick_count", tick_q[1].size(), 1);
    chk("t2_tick_at", tick_q[1][0] - n, 3);
    rd(BASE + 32'h0C, v);
    chk("t2_ctrl_done", v, 32'hA);
    wr(BASE + 32'h0C, 32'h8);
    rd(BASE + 32'h0C, v);
    chk("t2_ctrl_cleared", v, 0);

    // ch0 LIMIT 4 -> 1 mid-period
    wr(BASE + 32'h00, 4);
    clear_q();
    wr(BASE + 32'h04, 1);
    wait_ticks(0, 1, 50, "t3_first");
    wr(BASE + 32'h00, 1);
    rd(BASE + 32'h04, v);
    chk("t3_pending", v, 32'h5);
    wait_ticks(0, 4, 50, "t3_ticks");
    chk("t3_period_a", tick_q[0][1] - tick_q[0][0], 5);
    chk("t3_period_b", tick_q[0][2] - tick_q[0][1], 2);
    chk("t3_period_c", tick_q[0][3] - tick_q[0][2], 2);
    rd(BASE + 32'h04, v);
    chk("t3_pending_clr", v, 32'h1);
    wr(BASE + 32'h04, 0);

    // LIMIT write on the wrap edge, then EN<-0 on the wrap edge
    wr(BASE + 32'h00, 4);
    clear_q();
    wr(BASE + 32'h04, 1);
    n = cyc;
    while (cyc < n + 9) idle(1);
    wr(BASE + 32'h00, 2);
    wait_ticks(0, 4, 60, "t4_ticks");
    chk("t4_tick0", tick_q[0][0] - n, 5);
    chk("t4_tick1", tick_q[0][1] - n, 10);
    chk("t4_tick2", tick_q[0][2] - n, 15);
    chk("t4_tick3", tick_q[0][3] - n, 18);
    while (cyc < n + 23) idle(1);
    wr(BASE + 32'h04, 0);
    idle(10);
    chk("t4_dis_count", tick_q[0].size(), 5);
    chk("t4_dis_last", tick_q[0][tick_q[0].size() - 1] - n, 21);

    // mid-period reset with all channels running
    wr(BASE + 32'h40, 2);
    for (int c = 0; c < NCH; c++) wr(BASE + 32'(8 * c), 5);
    for (int c = 0; c < NCH; c++) wr(BASE + 32'(8 * c + 4), 1);
    idle(7);
    rst_n = 1'b0;
    idle(1);
    chk("t5_tick", tick, 0);
    chk("t5_sclk", sclk, 0);
    rst_n = 1'b1;
    clear_q();
    rd(BASE + 32'h40, v); chk("t5_prescale", v, 0);
    rd(BASE + 32'h00, v); chk("t5_limit0", v, 0);
    rd(BASE + 32'h0C, v); chk("t5_ctrl1", v, 0);
    idle(30);
    tot = 0;
    for (int c = 0; c < NCH; c++) tot += tick_q[c].size();
    chk("t5_no_ticks", tot, 0);

    // unmapped access and dropped upper write bits
    wr(BASE + 32'h40, 3);
    rd(BASE + 32'h44, v); chk("t6_unmapped_rd", v, 0);
    wr(BASE + 32'h44, 32'hFFFF_FFFF);
    rd(BASE + 32'h40, v); chk("t6_prescale_kept", v, 3);
    rd(BASE + 32'h44, v); chk("t6_unmapped_rd2", v, 0);
    wr(BASE + 32'h00, 32'hFF00_0005);
    idle(1);
    rd(BASE + 32'h00, v); chk("t6_trunc", v, 5);

    // LIMIT=0 PRESCALE=0: continuous tick
    wr(BASE + 32'h40, 0);
    wr(BASE + 32'h00, 0);
    clear_q();
    wr(BASE + 32'h04, 1);
    idle(10);
    chk("t7_continuous", tick_q[0].size(), 9);
    wr(BASE + 32'h04, 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 11);
      if (k < 4) begin
        a = BASE + 32'(8 * $urandom_range(0, NCH - 1));
        d = $urandom_range(0, 6);
      end else if (k < 9) begin
        a = BASE + 32'(8 * $urandom_range(0, NCH - 1) + 4);
        d = {28'h0, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8)};
      end else if (k < 11) begin
        a = BASE + 32'h40;
        d = $urandom_range(0, 3);
      end else begin
        a = BASE + 32'(4 * $urandom_range(17, 20));
        d = $urandom;
      end
      if ($urandom_range(0, 7) == 0) d = d | ($urandom & 32'hFF00_0000);
      bus_addr = a; bus_wdata = d;
      bus_wr = (r < 3) || (r == 5);
      bus_rd = (r >= 3 && r < 6);
      @(posedge clk); #2;
      bus_wr = 1'b0; bus_rd = 1'b0;
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
